botassium_mem_copier: RTL and testbench

BOTASSIUM_MEM_COPIER -- requirements
Module: botassium_mem_copier

---
 rtl/botassium_mem_copier.sv | 154 +++++++++++++++
 tb/tb_botassium_mem_copier.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/botassium_mem_copier.sv
// Word-by-word memory copier driving an Avalon-MM master port.
// Each word is read, captured, then written back at the destination offset.
module botassium_mem_copier #(
  parameter int ADDR_W  = 7,
  parameter int MAX_LEN = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [7:0]        length,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [31:0]       writedata,
  input  logic [31:0]       readdata,
  input  logic              waitrequest
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [7:0]        len;
  logic [7:0]        count;
  logic [31:0]       data;
  logic              err;
  logic              len_zero;
  logic              len_bad;
  logic              last_word;

  assign len_zero   = (length == 8'd0);
  assign len_bad    = ({1'b0, length} > MAX_LEN_W);
  assign last_word  = ((count + 8'd1) == len);
  assign byteenable = 4'hF;
  assign writedata  = data;

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // command latch, word counter and captured read word
  always_ff @(posedge clk) begin
    if (reset) begin
      src   <= {ADDR_W{1'b0}};
      dst   <= {ADDR_W{1'b0}};
      len   <= 8'd0;
      count <= 8'd0;
      data  <= 32'd0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src   <= src_addr;
            dst   <= dst_addr;
            len   <= length;
            count <= 8'd0;
            err   <= len_bad;
          end
        end
        CAP: data <= readdata;
        WR: begin
          if (!waitrequest) begin
            count <= count + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (len_zero || len_bad) ? FIN : RD;
        end else begin
          state_next = IDLE;
        end
      end
      RD: begin
        if (!waitrequest) begin
          state_next = CAP;
        end else begin
          state_next = RD;
        end
      end
      CAP: state_next = WR;
      WR: begin
        if (!waitrequest) begin
          state_next = last_word ? FIN : RD;
        end else begin
          state_next = WR;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // bus and status outputs decoded from the current state
  always_comb begin
    busy       = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    chipselect = 1'b0;
    write      = 1'b0;
    address    = {ADDR_W{1'b0}};
    case (state)
      IDLE: busy = 1'b0;
      RD: begin
        chipselect = 1'b1;
        address    = src + ADDR_W'(count);
      end
      CAP: begin
      end
      WR: begin
        chipselect = 1'b1;
        write      = 1'b1;
        address    = dst + ADDR_W'(count);
      end
      FIN: begin
        done  = 1'b1;
        error = err;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_botassium_mem_copier.sv
// Randomized bench for botassium_mem_copier: a slave memory plus an
// ascending-copy reference model predicting bus accesses, latency and contents.
module tb_botassium_mem_copier;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  src_addr;
  logic [6:0]  dst_addr;
  logic [7:0]  length;
  logic        busy;
  logic        done;
  logic        error;
  logic [6:0]  address;
  logic        chipselect;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [6:0]  exp_rd[$];
  logic [6:0]  exp_wa[$];
  logic [31:0] exp_wd[$];

  always #5 clk = ~clk;

  botassium_mem_copier dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .address    (address),
    .chipselect (chipselect),
    .write      (write),
    .byteenable (byteenable),
    .writedata  (writedata),
    .readdata   (readdata),
    .waitrequest(waitrequest)
  );

  // slave memory: read data returned one cycle after acceptance
  always @(posedge clk) begin
    if (chipselect && !waitrequest) begin
      if (write) mem[address] = writedata;
      else readdata <= mem[address];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference: ascending word copy with modulo-128 addressing
  task automatic model_cmd(input logic [6:0] s, input logic [6:0] d, input int n_rd, input int n_wr);
    logic [6:0] a;
    logic [6:0] b;
    for (int i = 0; i < n_rd; i++) begin
      a = s + 7'(i);
      exp_rd.push_back(a);
    end
    for (int i = 0; i < n_wr; i++) begin
      a = s + 7'(i);
      b = d + 7'(i);
      exp_wa.push_back(b);
      exp_wd.push_back(ref_mem[a]);
      ref_mem[b] = ref_mem[a];
    end
  endtask

  // mode: 0 no stalls, 1 random stalls, 2 two stall cycles per access
  task automatic run_cmd(input logic [6:0] s, input logic [6:0] d, input logic [7:0] l,
                         input int mode, input int abort_wr);
    int cyc, stalls, hold, wr_seen, mism, exp_lat;
    logic got_done, aborted, p_stall, p_write, exp_err, valid_len;
    logic [6:0]  p_addr;
    logic [31:0] p_wd;
    cyc = 1; stalls = 0; hold = 0; wr_seen = 0; mism = 0;
    got_done = 1'b0; aborted = 1'b0; p_stall = 1'b0; p_write = 1'b0;
    p_addr = 7'd0; p_wd = 32'd0;
    exp_err   = (l > 8'd128);
    valid_len = (l != 8'd0) && !exp_err;
    if (!valid_len) model_cmd(s, d, 0, 0);
    else if (abort_wr >= 0) model_cmd(s, d, abort_wr + 1, abort_wr);
    else model_cmd(s, d, int'(l), int'(l));

    start = 1'b1; src_addr = s; dst_addr = d; length = l; waitrequest = 1'b0;
    @(negedge clk);
    check_val("idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    src_addr = 7'($urandom); dst_addr = 7'($urandom); length = 8'($urandom);

    while (!got_done && !aborted && cyc < 2000) begin
      if (cyc == 2) start = 1'b1;
      else if (cyc == 3) start = 1'b0;
      if (mode == 1) waitrequest = ($urandom_range(0, 3) == 0);
      else if (mode == 2) waitrequest = chipselect && (hold < 2);
      else waitrequest = 1'b0;
      @(negedge clk);
      check_val("byteenable", {28'd0, byteenable}, 32'hF);
      if (p_stall) begin
        check_val("stall_addr", {25'd0, address}, {25'd0, p_addr});
        check_val("stall_write", {31'd0, write}, {31'd0, p_write});
        check_val("stall_wdata", writedata, p_wd);
      end
      if (abort_wr >= 0 && chipselect && write && wr_seen == abort_wr) begin
        waitrequest = 1'b1; reset = 1'b1; start = 1'b1; aborted = 1'b1;
      end else if (chipselect) begin
        if (waitrequest) begin
          stalls++; hold++;
        end else begin
          hold = 0;
          if (write) begin
            wr_seen++;
            if (exp_wa.size() == 0) check_val("unexp_write", 32'd1, 32'd0);
            else begin
              check_val("wr_addr", {25'd0, address}, {25'd0, exp_wa.pop_front()});
              check_val("wr_data", writedata, exp_wd.pop_front());
            end
          end else begin
            if (exp_rd.size() == 0) check_val("unexp_read", 32'd1, 32'd0);
            else check_val("rd_addr", {25'd0, address}, {25'd0, exp_rd.pop_front()});
          end
        end
      end
      p_stall = chipselect && waitrequest && !aborted;
      p_addr  = address; p_write = write; p_wd = writedata;
      if (done) begin
        got_done = 1'b1;
        exp_lat  = 3 * int'(l) * (valid_len ? 1 : 0) + 1 + stalls;
        check_val("latency", cyc, exp_lat);
        check_val("error", {31'd0, error}, {31'd0, exp_err});
        check_val("chipselect_fin", {31'd0, chipselect}, 32'd0);
        if (mode == 2) check_val("latency_stall2", cyc, 7 * int'(l) + 1);
      end else if (!aborted) begin
        check_val("busy", {31'd0, busy}, 32'd1);
        check_val("error_low", {31'd0, error}, 32'd0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;

    if (aborted) begin
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_error", {31'd0, error}, 32'd0);
        check_val("rst_cs", {31'd0, chipselect}, 32'd0);
        check_val("rst_write", {31'd0, write}, 32'd0);
        check_val("rst_addr", {25'd0, address}, 32'd0);
        check_val("rst_wdata", writedata, 32'd0);
        @(posedge clk); #1;
      end
    end else begin
      check_val("done_seen", {31'd0, got_done}, 32'd1);
      @(negedge clk);
      check_val("done_pulse", {31'd0, done}, 32'd0);
      check_val("idle_after", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
    end
    check_val("rd_left", exp_rd.size(), 32'd0);
    check_val("wr_left", exp_wa.size(), 32'd0);
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) mism++;
    check_val("mem_contents", mism, 32'd0);
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_addr = 7'd0; dst_addr = 7'd0;
    length = 8'd0; waitrequest = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[i] = 32'hA0 + 32'(i);
      ref_mem[i] = mem[i];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_busy", {31'd0, busy}, 32'd0);
    check_val("reset_done", {31'd0, done}, 32'd0);
    check_val("reset_error", {31'd0, error}, 32'd0);
    check_val("reset_cs", {31'd0, chipselect}, 32'd0);
    check_val("reset_write", {31'd0, write}, 32'd0);
    check_val("reset_addr", {25'd0, address}, 32'd0);
    check_val("reset_wdata", writedata, 32'd0);
    check_val("reset_be", {28'd0, byteenable}, 32'hF);
    @(posedge clk); #1;
    reset = 1'b0;

    run_cmd(7'h00, 7'h40, 8'd4, 0, -1);
    run_cmd(7'h7E, 7'h7F, 8'd3, 0, -1);
    run_cmd(7'h10, 7'h20, 8'd2, 2, -1);
    run_cmd(7'h05, 7'h09, 8'd0, 0, -1);
    run_cmd(7'h05, 7'h09, 8'd200, 0, -1);
    run_cmd(7'h05, 7'h09, 8'd129, 0, -1);
    run_cmd(7'h03, 7'h30, 8'd5, 0, 1);
    run_cmd(7'h50, 7'h60, 8'd3, 0, -1);
    run_cmd(7'h11, 7'h13, 8'd6, 1, -1);
    for (int k = 0; k < 8; k++) begin
      run_cmd(7'($urandom), 7'($urandom), 8'($urandom_range(1, 12)), 1, -1);
    end
    run_cmd(7'($urandom), 7'($urandom), 8'd128, 1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
